// File: rtl/mfp_fifo_pkg.sv
// ============================================================================
// Module      : mfp_fifo_pkg
// Description : Shared sizing helpers and constants for the mfp FIFO slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mfp_fifo_pkg;

    // Head + skid entries sitting after the memory's registered read.
    localparam int MFP_FIFO_OUT_ENTRIES = 2;

    // Pointers carry one extra wrap bit above the address bits.
    function automatic int mfp_fifo_ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int mfp_fifo_capacity(input int addr_width);
        return (1 << addr_width) + MFP_FIFO_OUT_ENTRIES;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mfp_fifo_ctl_if.sv
// ============================================================================
// Module      : mfp_fifo_ctl_if
// Description : Producer/consumer handshake bundle of the show-ahead FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mfp_fifo_ctl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) ();
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [ADDR_WIDTH+1:0] level;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level
    );
endinterface

`default_nettype wire

// File: rtl/mfp_dual_port_mem.sv
// ============================================================================
// Module      : mfp_dual_port_mem
// Description : Simple dual-port storage, one-cycle registered read,
//               read-during-write returns the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfp_dual_port_mem #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  i_wr_en,
    input  wire logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wr_data,
    input  wire logic                  i_rd_en,
    input  wire logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic      [DATA_WIDTH-1:0] o_read_data
);
    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_read_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_read_data <= r_mem[i_rd_addr];
        end
    end

    assign o_read_data = r_read_data;
endmodule

`default_nettype wire

// File: rtl/mfp_fifo_ctl.sv
// ============================================================================
// Module      : mfp_fifo_ctl
// Description : Show-ahead valid/ready FIFO controller; a head/skid buffer
//               hides the storage read latency. Optional occupancy counter
//               enabled by MFP_FIFO_CTL_LEVEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfp_fifo_ctl
    import mfp_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input wire logic       clk,
    input wire logic       rst_n,
    mfp_fifo_ctl_if.slave  bus
);
    localparam int c_PTR_W = mfp_fifo_ptr_width(ADDR_WIDTH);
    localparam int c_LVL_W = ADDR_WIDTH + 2;

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic                  r_rd_pending;
    logic                  r_head_full;
    logic                  r_skid_full;
    logic [DATA_WIDTH-1:0] r_head_data;
    logic [DATA_WIDTH-1:0] r_skid_data;

    logic                  w_mem_empty;
    logic                  w_mem_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rd_issue;
    logic                  w_head_take;
    logic [2:0]            w_buf_cnt;
    logic [DATA_WIDTH-1:0] w_rd_data;

    always_comb begin
        w_mem_empty = (r_wr_ptr == r_rd_ptr);
        w_mem_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                      (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
        w_push      = bus.in_valid && !w_mem_full;
        w_pop       = r_head_full && bus.out_ready;
        w_buf_cnt   = 3'(r_head_full) + 3'(r_skid_full) + 3'(r_rd_pending);
        // Only fetch when the word will have a buffer slot by the time it lands.
        w_rd_issue  = !w_mem_empty &&
                      (w_buf_cnt < 3'(MFP_FIFO_OUT_ENTRIES) + 3'(w_pop));
        w_head_take = !r_head_full || (w_pop && !r_skid_full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_rd_pending <= w_rd_issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_full <= 1'b0;
            r_skid_full <= 1'b0;
            r_head_data <= '0;
            r_skid_data <= '0;
        end else if (r_rd_pending) begin
            if (w_head_take) begin
                r_head_full <= 1'b1;
                r_head_data <= w_rd_data;
            end else begin
                if (w_pop && r_skid_full) begin
                    r_head_data <= r_skid_data;
                end
                r_skid_full <= 1'b1;
                r_skid_data <= w_rd_data;
            end
        end else if (w_pop) begin
            if (r_skid_full) begin
                r_head_data <= r_skid_data;
                r_skid_full <= 1'b0;
            end else begin
                r_head_full <= 1'b0;
            end
        end
    end

    mfp_dual_port_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk         (clk),
        .i_wr_en     (w_push),
        .i_wr_addr   (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data   (bus.in_data),
        .i_rd_en     (w_rd_issue),
        .i_rd_addr   (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_read_data (w_rd_data)
    );

    assign bus.in_ready  = !w_mem_full;
    assign bus.out_valid = r_head_full;
    assign bus.out_data  = r_head_data;

`ifdef MFP_FIFO_CTL_LEVEL_EN
    // Internal moves (issue, landing, skid shift) conserve the total, so the
    // count only tracks accepted and delivered words.
    logic [c_LVL_W-1:0] r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else begin
            r_level <= r_level + c_LVL_W'(w_push) - c_LVL_W'(w_pop);
        end
    end

    assign bus.level = r_level;
`else
    assign bus.level = '0;
`endif
endmodule

`default_nettype wire

// File: doc/mfp_fifo_ctl.md
# mfp_fifo_ctl

Show-ahead FIFO controller with valid/ready handshakes on both sides. It owns the write/read pointers and the read-issue logic for an `mfp_dual_port_mem` storage array, and hides that memory's one-cycle registered read latency behind a two-entry output buffer. It sits between any producer (UART RX, AHB slave, debug capture) and its consumer, and sustains one transfer per clock in each direction.

## Interface
- `ADDR_WIDTH`, 6: storage address width; memory depth is `2**ADDR_WIDTH`.
- `DATA_WIDTH`, 8: payload width.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a word.
- `in_data`  in  DATA_WIDTH  producer word.
- `in_ready`  out  1  FIFO accepts a word this cycle.
- `out_valid`  out  1  `out_data` holds the head word.
- `out_data`  out  DATA_WIDTH  head word; stable while `out_valid && !out_ready`.
- `out_ready`  in  1  consumer takes the head word.
- `level`  out  ADDR_WIDTH+2  total occupancy (see Configuration).

## Operation
- Pointers `wr_ptr`, `rd_ptr`: ADDR_WIDTH+1 bits; the MSB is the wrap bit. `mem_empty` = pointers equal; `mem_full` = low bits equal and MSBs differ. Both are decoded from registered pointers only.
- Push: `in_ready = !mem_full`. When `in_valid && in_ready`, write `in_data` at `wr_ptr[ADDR_WIDTH-1:0]` and increment `wr_ptr`, wrapping modulo `2**(ADDR_WIDTH+1)`.
- Output buffer: two entries, head and skid, plus an `rd_pending` flag that marks memory data arriving next cycle.
- Read issue (`rd_issue`):
  - Requires `!mem_empty`.
  - Also requires (head/skid occupancy + `rd_pending` − pop this cycle) < 2, where pop = `out_valid && out_ready`.
  - On issue: drive the memory read address with `rd_ptr` low bits, increment `rd_ptr`, and set `rd_pending` for the next cycle.
- Landing: when `rd_pending`, the memory's `read_data` goes into head if head is empty or is popped this cycle and skid is empty; otherwise it goes into skid. On a pop with skid full, skid moves to head.
- `out_valid` = head full. Ordering is strictly FIFO.
- Total capacity: `2**ADDR_WIDTH + 2` words.
- Simultaneous push and read from the same memory address cannot occur: reading requires `mem_empty` false, which is computed from registered pointers.
- Push and pop in the same cycle are always legal. Occupancy and `in_ready` respond only to registered state.
- Reset (asynchronous, any time, including mid-burst):
  - pointers = 0, `rd_pending` = 0, head and skid empty;
  - `out_valid` = 0, `in_ready` = 1, `level` = 0, `out_data` = 0;
  - memory contents are not cleared and are unreachable after reset.

## Timing
- Fall-through latency: word accepted at edge N → `out_valid` = 1 after edge N+2 when the FIFO was empty.
- Throughput: one push and one pop per cycle, continuously, once the output buffer is primed.
- `in_ready` deasserts after the edge that makes the memory full. It reasserts after the edge of the first read issue from full.
- `out_data` is a register output. `in_ready` and `out_valid` are register-derived, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- `MFP_FIFO_CTL_LEVEL_EN` defined: `level` = memory count (`wr_ptr - rd_ptr`, ADDR_WIDTH+1 bits) + `rd_pending` + head + skid.
  - Registered; updated every edge; range 0 to `2**ADDR_WIDTH + 2`.
- Not defined: `level` is tied to 0 and no counter logic is synthesized.

## Structure
- Shared package `mfp_fifo_pkg`: the pointer width function, `MFP_FIFO_OUT_ENTRIES = 2`, and the capacity formula.
- One sub-module: `mfp_dual_port_mem` instantiated as storage, with read-during-write semantics of returning old data and one-cycle read latency. All control logic lives in `mfp_fifo_ctl`.

## Test plan
- Single word: push 0xA5 at edge 0, `out_ready` = 1 → `out_valid` after edge 2, `out_data` = 0xA5; `out_valid` = 0 after the pop edge.
- Fill with `out_ready` = 0, ADDR_WIDTH = 2: push 0x01.. until `in_ready` = 0 → exactly 6 words accepted; `level` = 6 with the macro; then drain reads 0x01–0x06 in order.
- Streaming: `in_valid` = `out_ready` = 1 for 100 cycles with an incrementing pattern → after a 2-cycle fill, one output per cycle with no gaps and no reordering.
- Backpressure toggle: `out_ready` random at 50%, random pushes, 1000 words → scoreboard matches; `out_data` never changes while `out_valid && !out_ready`.
- Wrap-around: ADDR_WIDTH = 2, 20 fill/drain cycles of 3 words each → pointers wrap correctly, no spurious full or empty.
- Reset mid-burst: assert `rst_n` = 0 with 4 words buffered and `rd_pending` = 1 → `out_valid` = 0 and `in_ready` = 1 immediately; next push 0x3C is the first word out.
